lifo_drain: RTL and testbench

Downstream drain stage for the synchronous LIFO (`syn_lifo`). On a `start` command it pops the LIFO until empty and presents the words as a valid/ready stream with backpressure. The LIFO's one-cycle read latency is absorbed by a 2-entry output buffer. The stream's final word is flagged, and completion is reported with a `done` pulse and a word count.

---
 rtl/lifo_drain_pkg.sv | 16 +
 rtl/lifo_drain_if.sv | 12 +
 rtl/lifo_drain_skid_buf2.sv | 55 +++++
 rtl/lifo_drain.sv | 92 +++++++++
 tb/tb_lifo_drain.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lifo_drain_pkg.sv
// Shared state encoding and buffer sizing for the LIFO drain stage.
package lifo_drain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } drain_state_t;

   localparam int BUF_DEPTH = 2;
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
   localparam int PTR_W     = $clog2(BUF_DEPTH);
   localparam int DEM_W     = OCC_W + 1;

endpackage

// File: rtl/lifo_drain_if.sv
// Valid/ready output stream of the drain stage, with an end-of-drain marker.
interface lifo_drain_if #(
   parameter int WIDTH = 8
);
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;

   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/lifo_drain_skid_buf2.sv
// Two-entry FIFO of {data, last} that absorbs the LIFO read latency under
// backpressure; the head entry drives the output stream.
module skid_buf2
   import lifo_drain_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_last,
   output logic [OCC_W-1:0] occ,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
);

   logic [WIDTH-1:0]     data_q [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] last_q;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 deq;

   assign m_valid = (occ != '0);
   assign deq     = m_valid && m_ready;
   assign m_data  = data_q[rd_ptr];
   assign m_last  = m_valid && last_q[rd_ptr];

   // NOTE: state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: storage is cleared as well, so m_data reads zero after reset.
         for (int i = 0; i < BUF_DEPTH; i++) data_q[i] <= '0;
         last_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_en) begin
            data_q[wr_ptr] <= wr_data;
            last_q[wr_ptr] <= wr_last;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, deq})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/lifo_drain.sv
// Pops a LIFO until empty on start and streams the words out with
// backpressure, flagging the final word and reporting done plus a word count.
module lifo_drain
   import lifo_drain_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    count,
   output logic             re,
   input  logic             empty,
   input  logic [WIDTH-1:0] dout,
   lifo_drain_if.master     m
);

   localparam logic [CW-1:0]    COUNT_MAX = CW'(DEPTH);
   localparam logic [DEM_W-1:0] BUF_LIMIT = DEM_W'(BUF_DEPTH);

   drain_state_t     state;
   logic             inflight;
   logic [OCC_W-1:0] occ;
   logic             deq;
   logic [DEM_W-1:0] demand;

   assign deq    = m.m_valid && m.m_ready;
   assign demand = DEM_W'(occ) + DEM_W'(inflight) - DEM_W'(deq);
   // A pop is issued only if the word is sure of a free slot when it lands.
   assign re     = (state == DRAIN) && !empty && (demand < BUF_LIMIT);

   skid_buf2 #(.WIDTH(WIDTH)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (inflight),
      .wr_data (dout),
      .wr_last (empty),
      .occ     (occ),
      .m_valid (m.m_valid),
      .m_ready (m.m_ready),
      .m_data  (m.m_data),
      .m_last  (m.m_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= re;
         if (deq && (count != COUNT_MAX)) count <= count + CW'(1);
         case (state)
            IDLE: begin
               if (start) begin
                  count <= '0;
                  busy  <= 1'b1;
                  if (empty) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // The in-flight word captured while empty is the final one.
               if (inflight && empty) state <= FLUSH;
            end
            FLUSH: begin
               if (deq && m.m_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lifo_drain.sv
// Bench for lifo_drain: a behavioural LIFO feeds the DUT; output words are
// checked against the reversed push order held in a queue.
module tb_lifo_drain;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic [CW-1:0]    count;
   logic             re;
   logic             empty;
   logic [WIDTH-1:0] dout = '0;

   lifo_drain_if #(.WIDTH(WIDTH)) m_if ();

   lifo_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .count (count),
      .re    (re),
      .empty (empty),
      .dout  (dout),
      .m     (m_if)
   );

   always #5 clk = ~clk;

   // Behavioural LIFO: pop on re && !empty, word on dout the next cycle.
   logic [WIDTH-1:0] stack [DEPTH];
   int               sp = 0;
   logic             we = 1'b0;
   logic [WIDTH-1:0] wdata = '0;

   assign empty = (sp == 0);

   always @(posedge clk) begin
      if (we && !busy && sp < DEPTH) begin
         stack[sp] <= wdata;
         sp        <= sp + 1;
      end else if (re && !empty) begin
         dout <= stack[sp-1];
         sp   <= sp - 1;
      end
   end

   typedef struct {
      int         n_words;
      int         mode;
      logic [7:0] base;
      bit         poke;
      int         exp_count;
      logic [7:0] exp_first;
      int         exp_done_rel;
   } vec_t;

   vec_t             vecs [7];
   int               n_vec = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] exp_q [$];
   int               rel_cyc, hs_cnt, valid_cnt, done_cnt, done_rel, first_rel, underflow_cnt;
   logic [WIDTH-1:0] first_data, hold_data;
   logic             hold_last;
   logic             prev_stall = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic [WIDTH-1:0] exp_word;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (re && empty) underflow_cnt++;
         if (done) begin
            if (done_cnt == 0) done_rel = rel_cyc;
            done_cnt++;
         end
         if (prev_stall) begin
            check("hold_valid", 32'(m_if.m_valid), 1);
            check("hold_data", 32'(m_if.m_data), 32'(hold_data));
            check("hold_last", 32'(m_if.m_last), 32'(hold_last));
         end
         if (m_if.m_valid) begin
            if (valid_cnt == 0) first_rel = rel_cyc;
            valid_cnt++;
         end
         if (m_if.m_valid && m_if.m_ready) begin
            check("word_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               exp_word = exp_q.pop_front();
               if (hs_cnt == 0) first_data = m_if.m_data;
               check("m_data", 32'(m_if.m_data), 32'(exp_word));
               check("m_last", 32'(m_if.m_last), 32'(exp_q.size() == 0));
            end
            hs_cnt++;
         end
         prev_stall = m_if.m_valid && !m_if.m_ready;
         hold_data  = m_if.m_data;
         hold_last  = m_if.m_last;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      rel_cyc++;
   endtask

   function automatic logic ready_for(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (rel_cyc % 2) == 1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_word(input logic [WIDTH-1:0] v);
      we    = 1'b1;
      wdata = v;
      tick();
      we    = 1'b0;
   endtask

   task automatic clear_stats();
      hs_cnt = 0; valid_cnt = 0; done_cnt = 0; done_rel = 0;
      first_rel = 0; underflow_cnt = 0; first_data = '0;
      exp_q.delete();
      for (int i = sp - 1; i >= 0; i--) exp_q.push_back(stack[i]);
   endtask

   task automatic run_drain(input int mode, input bit poke, input int exp_n,
                            input logic [7:0] exp_first, input int exp_done_rel);
      clear_stats();
      start = 1'b1;
      m_if.m_ready = 1'b0;
      rel_cyc = 0;
      tick();
      start = 1'b0;
      check("re_at_t1", 32'(re), 32'(exp_n > 0));
      check("busy_at_t1", 32'(busy), 1);
      while (done_cnt == 0 && rel_cyc < 200) begin
         m_if.m_ready = ready_for(mode);
         start = poke && rel_cyc >= 2 && rel_cyc <= 4;
         tick();
      end
      start = 1'b0;
      m_if.m_ready = 1'b0;
      check("done_seen", 32'(done_cnt), 1);
      tick();
      check("busy_after_done", 32'(busy), 0);
      check("done_width", 32'(done_cnt), 1);
      check("handshakes", 32'(hs_cnt), 32'(exp_n));
      check("count", 32'(count), 32'(exp_n));
      check("leftover", 32'(exp_q.size()), 0);
      check("underflow", 32'(underflow_cnt), 0);
      if (exp_n > 0) check("first_word", 32'(first_data), 32'(exp_first));
      else           check("valid_cycles", 32'(valid_cnt), 0);
      if (exp_done_rel > 0) begin
         check("done_rel", 32'(done_rel), 32'(exp_done_rel));
         if (exp_n > 0) check("first_rel", 32'(first_rel), 3);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_re"}, 32'(re), 0);
      check({tag, "_m_valid"}, 32'(m_if.m_valid), 0);
      check({tag, "_m_last"}, 32'(m_if.m_last), 0);
      check({tag, "_m_data"}, 32'(m_if.m_data), 0);
      check({tag, "_count"}, 32'(count), 0);
   endtask

   initial begin
      int               n, remaining;
      logic [WIDTH-1:0] v;

      vecs = '{
         '{16, 0, 8'h00, 1'b0, 16, 8'h0F, 19},
         '{16, 1, 8'h00, 1'b0, 16, 8'h0F,  0},
         '{ 1, 0, 8'hA5, 1'b0,  1, 8'hA5,  4},
         '{ 0, 0, 8'h00, 1'b0,  0, 8'h00,  1},
         '{ 4, 0, 8'h10, 1'b1,  4, 8'h13,  7},
         '{ 2, 0, 8'hF0, 1'b0,  2, 8'hF1,  5},
         '{ 5, 1, 8'h30, 1'b0,  5, 8'h34,  0}
      };

      rst = 1'b1;
      start = 1'b0;
      m_if.m_ready = 1'b0;
      rel_cyc = 0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      foreach (vecs[k]) begin
         for (int i = 0; i < vecs[k].n_words; i++) push_word(vecs[k].base + 8'(i));
         run_drain(vecs[k].mode, vecs[k].poke, vecs[k].exp_count,
                   vecs[k].exp_first, vecs[k].exp_done_rel);
      end

      // Reset after five handshakes; words still in the LIFO survive it.
      for (int i = 0; i < 16; i++) push_word(8'(i));
      clear_stats();
      start = 1'b1;
      m_if.m_ready = 1'b1;
      rel_cyc = 0;
      tick();
      start = 1'b0;
      while (hs_cnt < 5 && rel_cyc < 100) begin
         m_if.m_ready = 1'b1;
         tick();
      end
      check("pre_reset_hs", 32'(hs_cnt), 5);
      rst = 1'b1;
      m_if.m_ready = 1'b0;
      tick();
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      remaining = sp;
      check("lifo_kept_words", 32'(remaining > 0 && remaining <= 11), 1);
      run_drain(0, 1'b0, remaining, 8'(remaining - 1), remaining + 3);

      for (int r = 0; r < 12; r++) begin
         n = $urandom_range(0, 16);
         v = '0;
         for (int i = 0; i < n; i++) begin
            v = 8'($urandom);
            push_word(v);
         end
         run_drain(2, 1'b0, n, v, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
